// File: rtl/mem_arctec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arctec_pkg
// Purpose  : Shared definitions for the memory request arbiter family:
//            FSM state encoding, default address width, statistics counter
//            width and the requester-ID width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arctec_pkg;

    // Default address width, matching the CPU trace address width.
    localparam int ADDR_W_DEFAULT = 11;

    // Width of each per-requester statistics counter.
    localparam int STAT_W = 16;

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Requester ID width: clog2 of the requester count, never below one bit
    // so a single-requester build still has a legal mem_id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Grants the first set request
//            bit strictly after the pointer, wrapping cyclically.
// Ports    : req         in  NUM_REQ  request vector
//            ptr         in  PTR_W    index of the most recent winner
//            grant       out NUM_REQ  one-hot grant (zero when no request)
//            grant_valid out 1        at least one request is present
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import mem_arctec_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid
);

    logic [NUM_REQ-1:0] w_above;
    logic [NUM_REQ-1:0] w_masked;
    logic [NUM_REQ-1:0] w_pool;

    // Mark positions that come after the pointer in plain index order.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_mask
        assign w_above[k] = (PTR_W'(k) > ptr);
    end

    // Requests above the pointer win first; if none, the search wraps and
    // the lowest-indexed request wins. Isolating the lowest set bit of the
    // chosen pool gives the cyclic "first at or after ptr+1" result.
    assign w_masked    = req & w_above;
    assign w_pool      = (|w_masked) ? w_masked : req;
    assign grant       = w_pool & (~w_pool + NUM_REQ'(1));
    assign grant_valid = |req;

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Round-robin arbiter sharing one cache request port among
//            NUM_REQ trace-driven CPU address sources, with exactly one
//            transaction outstanding and a response timeout.
// Ports    : clk, reset (async, active high)
//            req_valid/req_addr/req_ready    requester handshake
//            resp_valid/resp_hit             response back to requester
//            mem_valid/mem_addr/mem_id/mem_ready   cache request
//            mem_resp_valid/mem_resp_hit     cache response
//            busy, timeout_err (sticky)
//            stat_grants/stat_hits           only with MEM_ARB_STATS_EN
// Options  : `define MEM_ARB_STATS_EN adds saturating per-requester grant
//            and hit counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
    import mem_arctec_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int ADDR_W  = ADDR_W_DEFAULT,
    parameter  int TIMEOUT = 64,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_hit,
    output logic                      mem_valid,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [ID_W-1:0]           mem_id,
    input  logic                      mem_ready,
    input  logic                      mem_resp_valid,
    input  logic                      mem_resp_hit,
    output logic                      busy,
    output logic                      timeout_err
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_grants,
    output logic [NUM_REQ*STAT_W-1:0] stat_hits
`endif
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ID_W-1:0]     r_mem_id;
    logic                r_mem_valid;
    logic [NUM_REQ-1:0]  r_resp_valid;
    logic                r_resp_hit;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_timeout_err;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_grant_valid;
    logic [ID_W-1:0]     w_gnt_id;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic [NUM_REQ-1:0]  w_req_hs;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_pick (
        .req         (req_valid),
        .ptr         (r_rr_ptr),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // Encode the one-hot grant into an index and select its address.
    always_comb begin
        w_gnt_id   = '0;
        w_gnt_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_gnt_id   = ID_W'(k);
                w_gnt_addr = req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Acceptance is offered only while idle; the grant already implies the
    // matching req_valid bit, so ready and handshake coincide.
    assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    assign w_req_hs  = req_ready & req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= ID_W'(NUM_REQ - 1);
            r_mem_addr    <= '0;
            r_mem_id      <= '0;
            r_mem_valid   <= 1'b0;
            r_resp_valid  <= '0;
            r_resp_hit    <= 1'b0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses.
            r_resp_valid <= '0;
            r_resp_hit   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_mem_addr  <= w_gnt_addr;
                        r_mem_id    <= w_gnt_id;
                        r_rr_ptr    <= w_gnt_id;
                        r_mem_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Any cache response here is stale and deliberately ignored.
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response on the expiry cycle still counts as a response.
                    if (mem_resp_valid) begin
                        r_resp_valid <= NUM_REQ'(1) << r_mem_id;
                        r_resp_hit   <= mem_resp_hit;
                        r_state      <= ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_hit    = r_resp_hit;
    assign mem_valid   = r_mem_valid;
    assign mem_addr    = r_mem_addr;
    assign mem_id      = r_mem_id;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;

`ifdef MEM_ARB_STATS_EN
    // Per-requester saturating counters; hits are counted on the outgoing
    // response pulse so they follow exactly what the requester observes.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        logic [STAT_W-1:0] r_grants;
        logic [STAT_W-1:0] r_hits;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_grants <= '0;
                r_hits   <= '0;
            end else begin
                if (w_req_hs[k] && (r_grants != '1)) begin
                    r_grants <= r_grants + STAT_W'(1);
                end
                if (r_resp_valid[k] && r_resp_hit && (r_hits != '1)) begin
                    r_hits <= r_hits + STAT_W'(1);
                end
            end
        end

        assign stat_grants[k*STAT_W +: STAT_W] = r_grants;
        assign stat_hits[k*STAT_W +: STAT_W]   = r_hits;
    end
`else
    // Handshake vector only feeds the statistics counters.
    logic w_unused_hs;
    assign w_unused_hs = |w_req_hs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Purpose  : Self-checking bench for mem_req_arbiter (NUM_REQ=2, ADDR_W=11,
//            TIMEOUT=8). Directed scenarios followed by randomized
//            transactions checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic                      resp_hit;
    logic                      mem_valid;
    logic [ADDR_W-1:0]         mem_addr;
    logic [ID_W-1:0]           mem_id;
    logic                      mem_ready = 1'b0;
    logic                      mem_resp_valid = 1'b0;
    logic                      mem_resp_hit = 1'b0;
    logic                      busy;
    logic                      timeout_err;
`ifdef MEM_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     stat_grants;
    logic [NUM_REQ*16-1:0]     stat_hits;
`endif

    mem_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_id         (mem_id),
        .mem_ready      (mem_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_hit   (mem_resp_hit),
        .busy           (busy),
        .timeout_err    (timeout_err)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_hits      (stat_hits)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index of the last granted requester and the
    // expected sticky error flag.
    int last_g  = NUM_REQ - 1;
    bit err_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting index after the last winner, cyclically.
    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (v[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, starting with the DUT idle at posedge+1.
    // stall: cycles mem_ready is held low; dly: idle WAIT cycles before the
    // response; respond=0 lets the timeout expire.
    task automatic txn(input logic [NUM_REQ-1:0] valids,
                       input logic [NUM_REQ*ADDR_W-1:0] addrs,
                       input int stall, input int dly, input bit hit, input bit respond);
        int g;
        logic [ADDR_W-1:0] ea;
        g  = model_pick(valids, last_g);
        ea = addrs[g*ADDR_W +: ADDR_W];
        req_valid = valids;
        req_addr  = addrs;
        #1;
        check("req_ready_grant", 32'(req_ready), 32'(NUM_REQ'(1) << g));
        check("busy_idle", 32'(busy), 0);
        step();
        // Other requesters keep asking; ready must stay low while busy.
        req_valid      = valids & ~(NUM_REQ'(1) << g);
        mem_ready      = (stall == 0);
        mem_resp_valid = (stall != 0);
        #1;
        check("mem_valid_issue", 32'(mem_valid), 1);
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("mem_id", 32'(mem_id), 32'(g));
        check("req_ready_busy", 32'(req_ready), 0);
        check("resp_valid_one_cycle", 32'(resp_valid), 0);
        for (int i = 0; i < stall; i++) begin
            step();
            if (i == stall - 1) begin
                mem_ready      = 1'b1;
                mem_resp_valid = 1'b0;
            end
            #1;
            check("stall_mem_valid", 32'(mem_valid), 1);
            check("stall_mem_addr", 32'(mem_addr), 32'(ea));
            check("stall_mem_id", 32'(mem_id), 32'(g));
            check("stall_req_ready", 32'(req_ready), 0);
        end
        step();
        mem_ready = 1'b0;
        check("mem_valid_wait", 32'(mem_valid), 0);
        check("busy_wait", 32'(busy), 1);
        if (respond) begin
            for (int i = 0; i < dly; i++) begin
                check("wait_no_resp", 32'(resp_valid), 0);
                step();
            end
            mem_resp_valid = 1'b1;
            mem_resp_hit   = hit;
            step();
            mem_resp_valid = 1'b0;
            mem_resp_hit   = 1'b0;
            check("resp_valid", 32'(resp_valid), 32'(NUM_REQ'(1) << g));
            check("resp_hit", 32'(resp_hit), 32'(hit));
            check("busy_after_resp", 32'(busy), 0);
            check("timeout_err_resp", 32'(timeout_err), 32'(err_exp));
        end else begin
            for (int i = 0; i < TIMEOUT; i++) begin
                check("timeout_busy", 32'(busy), 1);
                check("timeout_err_early", 32'(timeout_err), 32'(err_exp));
                check("timeout_no_resp", 32'(resp_valid), 0);
                step();
            end
            err_exp = 1'b1;
            check("timeout_err_set", 32'(timeout_err), 1);
            check("timeout_busy_end", 32'(busy), 0);
            check("timeout_no_resp_end", 32'(resp_valid), 0);
        end
        last_g = g;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic async_reset(input string where);
        #2;
        reset = 1'b1;
        #1;
        check({where, "_busy"}, 32'(busy), 0);
        check({where, "_mem_valid"}, 32'(mem_valid), 0);
        check({where, "_timeout_err"}, 32'(timeout_err), 0);
        check({where, "_resp_valid"}, 32'(resp_valid), 0);
        last_g  = NUM_REQ - 1;
        err_exp = 1'b0;
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_REQ-1:0] rv;
        logic [NUM_REQ*ADDR_W-1:0] ra;

        // Reset state.
        step();
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_id", 32'(mem_id), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        reset = 1'b0;
        step();

        // Single request, zero-wait cache, hit.
        txn(2'b01, {11'h000, 11'h1A5}, 0, 0, 1'b1, 1'b1);
        // Requester 1 alone, miss.
        txn(2'b10, {11'h0AA, 11'h000}, 0, 1, 1'b0, 1'b1);
        // Contention: expected order 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, {11'h020, 11'h010}, 0, 0, 1'(i), 1'b1);
            check("contention_order", 32'(last_g), 32'(i % 2));
        end
        // Miss stall: mem_ready low for 5 cycles.
        txn(2'b11, {11'h444, 11'h333}, 5, 2, 1'b0, 1'b1);
        // Response exactly on the expiry cycle: normal response, no error.
        txn(2'b01, {11'h000, 11'h155}, 0, TIMEOUT - 1, 1'b1, 1'b1);
        check("expiry_no_err", 32'(timeout_err), 0);
        // Timeout abort, then normal grant afterwards.
        txn(2'b10, {11'h2A2, 11'h000}, 1, 0, 1'b0, 1'b0);
        txn(2'b11, {11'h7FF, 11'h001}, 0, 0, 1'b1, 1'b1);
        check("err_sticky", 32'(timeout_err), 1);

        // Reset during ISSUE.
        req_valid = 2'b10;
        req_addr  = {11'h123, 11'h000};
        step();
        req_valid = '0;
        check("pre_rst_issue_valid", 32'(mem_valid), 1);
        async_reset("rst_issue");

        // Reset during WAIT.
        req_valid = 2'b10;
        req_addr  = {11'h321, 11'h000};
        step();
        req_valid = '0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        check("pre_rst_wait_busy", 32'(busy), 1);
        async_reset("rst_wait");
        // After release requester 0 wins a tie.
        txn(2'b11, {11'h0B0, 11'h0A0}, 0, 0, 1'b1, 1'b1);
        check("tie_after_reset", 32'(last_g), 0);

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            rv = NUM_REQ'($urandom_range(1, 3));
            ra = (NUM_REQ*ADDR_W)'({$urandom, $urandom});
            txn(rv, ra, int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT - 1)),
                1'($urandom), ($urandom_range(0, 7) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
